// File: rtl/light_pkg.sv
// Shared encodings and lookup tables for the traffic-light matrix/segment driver.
package light_pkg;

  typedef enum logic [1:0] {
    ST_GREEN   = 2'd0,
    ST_YELLOW  = 2'd1,
    ST_RED     = 2'd2,
    ST_ILLEGAL = 2'd3
  } light_state_e;

  // Glyph rows 0..7, bit 7 is the leftmost column.
  localparam logic [0:7][7:0] GLYPH_GREEN  = {8'h18, 8'h3C, 8'h7E, 8'hFF,
                                              8'h18, 8'h18, 8'h18, 8'h18};
  localparam logic [0:7][7:0] GLYPH_YELLOW = {8'h3C, 8'h42, 8'h81, 8'h81,
                                              8'h81, 8'h81, 8'h42, 8'h3C};
  localparam logic [0:7][7:0] GLYPH_RED    = {8'h81, 8'h42, 8'h24, 8'h18,
                                              8'h18, 8'h24, 8'h42, 8'h81};

  // Digit patterns 0..9, gfedcba, active-high.
  localparam logic [0:9][6:0] SEG_TABLE = {7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  localparam logic [3:0] COUNT_RESET = 4'd15;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to seven-segment (gfedcba, active-high); non-decimal codes go dark.
module seg7_decode
  import light_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  // Table lookup over the ten legal digits.
  always_comb begin
    seg_o = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (digit_i == i[3:0]) seg_o = SEG_TABLE[i];
    end
  end

endmodule

// File: rtl/light_display_driver.sv
// Scans an 8x8 bicolour matrix one row per scan tick and multiplexes a two-digit
// countdown onto a seven-segment display. Inputs are captured once per frame.
module light_display_driver
  import light_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_en,
  input  logic [1:0] state,
  input  logic [3:0] count_down,
  output logic [7:0] row,
  output logic [7:0] col_g,
  output logic [7:0] col_r,
  output logic [6:0] seg,
  output logic [1:0] digit_en
);

  localparam logic [6:0] SEG_MASK = {7{SEG_ACTIVE_LOW}};
  localparam logic [1:0] DEN_MASK = {2{SEG_ACTIVE_LOW}};

  logic [2:0]   idx_q;
  light_state_e st_q;
  logic [3:0]   cnt_q;
  logic         dsel_q;   // 0 = ones strobe, 1 = tens strobe
  logic         scan_q;

  logic [7:0] row_q, col_g_q, col_r_q;
  logic [6:0] seg_q;
  logic [1:0] den_q;

  logic [7:0] row_d, col_g_d, col_r_d;
  logic [6:0] seg_d, dec_seg;
  logic [1:0] den_d;
  logic [3:0] dec_in, ones;
  logic       tens;

  // Stage 1: advance row index and digit strobe, capture shadow inputs at frame end.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q  <= '0;
      st_q   <= ST_GREEN;
      cnt_q  <= COUNT_RESET;
      dsel_q <= 1'b0;
      scan_q <= 1'b0;
    end else begin
      scan_q <= scan_en;
      if (scan_en) begin
        idx_q  <= idx_q + 3'd1;
        dsel_q <= ~dsel_q;
        if (idx_q == 3'd7) begin
          st_q  <= light_state_e'(state);
          cnt_q <= count_down;
        end
      end
    end
  end

  seg7_decode u_seg7_decode (
    .digit_i (dec_in),
    .seg_o   (dec_seg)
  );

  // Stage 2 next-state: glyph routing, blink, decimal split and polarity.
  always_comb begin
    col_g_d = '0;
    col_r_d = '0;
    case (st_q)
      ST_GREEN:  col_g_d = GLYPH_GREEN[idx_q];
      ST_RED:    col_r_d = GLYPH_RED[idx_q];
      ST_YELLOW: begin
        if (cnt_q[0]) begin
          col_g_d = GLYPH_YELLOW[idx_q];
          col_r_d = GLYPH_YELLOW[idx_q];
        end
      end
      default: ;
    endcase
    row_d  = 8'd1 << idx_q;
    tens   = (cnt_q >= 4'd10);
    ones   = tens ? (cnt_q - 4'd10) : cnt_q;
    dec_in = dsel_q ? {3'b000, tens} : ones;
    seg_d  = ((dsel_q && !tens) ? 7'h00 : dec_seg) ^ SEG_MASK;
    den_d  = (dsel_q ? 2'b10 : 2'b01) ^ DEN_MASK;
  end

  // Stage 2: output registers load one cycle after the scan tick and hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_q   <= 8'h01;
      col_g_q <= GLYPH_GREEN[0];
      col_r_q <= 8'h00;
      seg_q   <= SEG_TABLE[5] ^ SEG_MASK;
      den_q   <= 2'b01 ^ DEN_MASK;
    end else if (scan_q) begin
      row_q   <= row_d;
      col_g_q <= col_g_d;
      col_r_q <= col_r_d;
      seg_q   <= seg_d;
      den_q   <= den_d;
    end
  end

  assign row      = row_q;
  assign col_g    = col_g_q;
  assign col_r    = col_r_q;
  assign seg      = seg_q;
  assign digit_en = den_q;

endmodule

// File: tb/tb_light_display_driver.sv
// Directed bench: a frame-by-frame vector table plus hand sequences for latency,
// reset/scan collision and hold behaviour. A second instance runs active-low.
module tb_light_display_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scan_en = 1'b0;
  logic [1:0] state = 2'd0;
  logic [3:0] count_down = 4'd15;

  logic [7:0] row, col_g, col_r, row_n, col_g_n, col_r_n;
  logic [6:0] seg, seg_n;
  logic [1:0] digit_en, digit_en_n;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  light_display_driver #(.SEG_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .reset(reset), .scan_en(scan_en), .state(state),
    .count_down(count_down), .row(row), .col_g(col_g), .col_r(col_r),
    .seg(seg), .digit_en(digit_en)
  );

  light_display_driver #(.SEG_ACTIVE_LOW(1'b1)) dut_n (
    .clk(clk), .reset(reset), .scan_en(scan_en), .state(state),
    .count_down(count_down), .row(row_n), .col_g(col_g_n), .col_r(col_r_n),
    .seg(seg_n), .digit_en(digit_en_n)
  );

  typedef struct packed {
    logic [1:0] st;
    logic [3:0] cnt;
    logic [7:0] row;
    logic [7:0] cg;
    logic [7:0] cr;
    logic [6:0] seg;
    logic [1:0] den;
  } vec_t;

  vec_t v [39];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] er, input logic [7:0] eg,
                         input logic [7:0] ec, input logic [6:0] es, input logic [1:0] ed);
    chk({tag, ".row"},   {24'd0, row},      {24'd0, er});
    chk({tag, ".col_g"}, {24'd0, col_g},    {24'd0, eg});
    chk({tag, ".col_r"}, {24'd0, col_r},    {24'd0, ec});
    chk({tag, ".seg"},   {25'd0, seg},      {25'd0, es});
    chk({tag, ".den"},   {30'd0, digit_en}, {30'd0, ed});
    chk({tag, ".n_row"}, {24'd0, row_n},    {24'd0, er});
    chk({tag, ".n_seg"}, {25'd0, seg_n},    {25'd0, ~es});
    chk({tag, ".n_den"}, {30'd0, digit_en_n}, {30'd0, ~ed});
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic do_scan();
    @(negedge clk) scan_en = 1'b1;
    @(negedge clk) scan_en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    //            st    cnt    row    col_g  col_r  seg    den
    v[0]  = '{2'd0, 4'd15, 8'h02, 8'h3C, 8'h00, 7'h06, 2'b10};
    v[1]  = '{2'd0, 4'd15, 8'h04, 8'h7E, 8'h00, 7'h6D, 2'b01};
    v[2]  = '{2'd0, 4'd15, 8'h08, 8'hFF, 8'h00, 7'h06, 2'b10};
    v[3]  = '{2'd2, 4'd12, 8'h10, 8'h18, 8'h00, 7'h6D, 2'b01};
    v[4]  = '{2'd2, 4'd12, 8'h20, 8'h18, 8'h00, 7'h06, 2'b10};
    v[5]  = '{2'd2, 4'd12, 8'h40, 8'h18, 8'h00, 7'h6D, 2'b01};
    v[6]  = '{2'd2, 4'd12, 8'h80, 8'h18, 8'h00, 7'h06, 2'b10};
    v[7]  = '{2'd2, 4'd12, 8'h01, 8'h00, 8'h81, 7'h5B, 2'b01};
    v[8]  = '{2'd2, 4'd12, 8'h02, 8'h00, 8'h42, 7'h06, 2'b10};
    v[9]  = '{2'd2, 4'd12, 8'h04, 8'h00, 8'h24, 7'h5B, 2'b01};
    v[10] = '{2'd2, 4'd12, 8'h08, 8'h00, 8'h18, 7'h06, 2'b10};
    v[11] = '{2'd1, 4'd5,  8'h10, 8'h00, 8'h18, 7'h5B, 2'b01};
    v[12] = '{2'd1, 4'd5,  8'h20, 8'h00, 8'h24, 7'h06, 2'b10};
    v[13] = '{2'd1, 4'd5,  8'h40, 8'h00, 8'h42, 7'h5B, 2'b01};
    v[14] = '{2'd1, 4'd5,  8'h80, 8'h00, 8'h81, 7'h06, 2'b10};
    v[15] = '{2'd1, 4'd5,  8'h01, 8'h3C, 8'h3C, 7'h6D, 2'b01};
    v[16] = '{2'd1, 4'd5,  8'h02, 8'h42, 8'h42, 7'h00, 2'b10};
    v[17] = '{2'd1, 4'd4,  8'h04, 8'h81, 8'h81, 7'h6D, 2'b01};
    v[18] = '{2'd1, 4'd4,  8'h08, 8'h81, 8'h81, 7'h00, 2'b10};
    v[19] = '{2'd1, 4'd4,  8'h10, 8'h81, 8'h81, 7'h6D, 2'b01};
    v[20] = '{2'd1, 4'd4,  8'h20, 8'h81, 8'h81, 7'h00, 2'b10};
    v[21] = '{2'd1, 4'd4,  8'h40, 8'h42, 8'h42, 7'h6D, 2'b01};
    v[22] = '{2'd1, 4'd4,  8'h80, 8'h3C, 8'h3C, 7'h00, 2'b10};
    v[23] = '{2'd1, 4'd4,  8'h01, 8'h00, 8'h00, 7'h66, 2'b01};
    v[24] = '{2'd3, 4'd9,  8'h02, 8'h00, 8'h00, 7'h00, 2'b10};
    v[25] = '{2'd3, 4'd9,  8'h04, 8'h00, 8'h00, 7'h66, 2'b01};
    v[26] = '{2'd3, 4'd9,  8'h08, 8'h00, 8'h00, 7'h00, 2'b10};
    v[27] = '{2'd3, 4'd9,  8'h10, 8'h00, 8'h00, 7'h66, 2'b01};
    v[28] = '{2'd3, 4'd9,  8'h20, 8'h00, 8'h00, 7'h00, 2'b10};
    v[29] = '{2'd3, 4'd9,  8'h40, 8'h00, 8'h00, 7'h66, 2'b01};
    v[30] = '{2'd3, 4'd9,  8'h80, 8'h00, 8'h00, 7'h00, 2'b10};
    v[31] = '{2'd3, 4'd9,  8'h01, 8'h00, 8'h00, 7'h6F, 2'b01};
    v[32] = '{2'd3, 4'd9,  8'h02, 8'h00, 8'h00, 7'h00, 2'b10};
    v[33] = '{2'd3, 4'd9,  8'h04, 8'h00, 8'h00, 7'h6F, 2'b01};
    v[34] = '{2'd3, 4'd9,  8'h08, 8'h00, 8'h00, 7'h00, 2'b10};
    v[35] = '{2'd3, 4'd9,  8'h10, 8'h00, 8'h00, 7'h6F, 2'b01};
    v[36] = '{2'd3, 4'd9,  8'h20, 8'h00, 8'h00, 7'h00, 2'b10};
    v[37] = '{2'd3, 4'd9,  8'h40, 8'h00, 8'h00, 7'h6F, 2'b01};
    v[38] = '{2'd3, 4'd9,  8'h80, 8'h00, 8'h00, 7'h00, 2'b10};

    do_reset();
    chk_all("reset", 8'h01, 8'h18, 8'h00, 7'h6D, 2'b01);

    for (int i = 0; i < 39; i++) begin
      state      = v[i].st;
      count_down = v[i].cnt;
      do_scan();
      chk_all($sformatf("vec%0d", i), v[i].row, v[i].cg, v[i].cr, v[i].seg, v[i].den);
    end

    // Latency: outputs still show the old row right after the sampling edge.
    do_reset();
    state = 2'd0; count_down = 4'd15;
    @(negedge clk) scan_en = 1'b1;
    @(posedge clk) #1;
    scan_en = 1'b0;
    chk("lat.before", {24'd0, row}, 32'h01);
    @(posedge clk) #1;
    chk("lat.after", {24'd0, row}, 32'h02);
    chk("lat.col_g", {24'd0, col_g}, 32'h3C);

    // Reset wins over a simultaneous scan tick at row index 5.
    do_reset();
    state = 2'd2; count_down = 4'd12;
    for (int i = 0; i < 5; i++) do_scan();
    chk("mid.row5", {24'd0, row}, 32'h20);
    @(negedge clk) begin reset = 1'b1; scan_en = 1'b1; end
    @(negedge clk) begin reset = 1'b0; scan_en = 1'b0; end
    @(negedge clk);
    chk_all("coll", 8'h01, 8'h18, 8'h00, 7'h6D, 2'b01);
    do_scan();
    chk_all("coll.next", 8'h02, 8'h3C, 8'h00, 7'h06, 2'b10);

    // Outputs hold with no scan tick, even as inputs change.
    state = 2'd1; count_down = 4'd3;
    repeat (6) @(negedge clk);
    chk_all("hold", 8'h02, 8'h3C, 8'h00, 7'h06, 2'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
